// File: rtl/cic_dec_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : cic_dec_ctrl
//  Description : Control block for a CIC decimator. Generates the decimation
//                pulse, flushes the CIC filter on start or on a rate change,
//                and waits out the differentiator settling time before it
//                marks output samples valid.
//  Revision    : 1.0 - initial release
// ============================================================================
module cic_dec_ctrl #(
    parameter int          NUM_STAGES   = 5,
    parameter int          FLUSH_CYCLES = 8,
    parameter logic [7:0]  DEFAULT_RATE = 8'd8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic [7:0]  rate_in,
    input  logic        rate_load,
    output logic [7:0]  dec_rate,
    output logic        dec_clk,
    output logic        cic_reset,
    output logic        out_valid,
    output logic        rate_err,
    output logic [1:0]  state
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_FLUSH  = 2'd1;
    localparam logic [1:0] c_SETTLE = 2'd2;
    localparam logic [1:0] c_RUN    = 2'd3;

    localparam int c_FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam int c_SW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES + 1) : 1;
    localparam logic [c_FW-1:0] c_FLUSH_LAST = c_FW'(FLUSH_CYCLES - 1);
    localparam logic [c_SW-1:0] c_SETTLE_LAST = c_SW'(NUM_STAGES - 1);

    logic [1:0]       r_state;
    logic [c_FW-1:0]  r_flush_cnt;
    logic [c_SW-1:0]  r_settle_cnt;
    logic [6:0]       r_phase;
    logic [7:0]       r_dec_rate;
    logic [7:0]       r_pending_rate;
    logic             r_restart;
    logic             r_rate_err;
    logic             r_dec_clk;
    logic             r_out_valid;

    logic [1:0]       w_state_nxt;
    logic             w_flush_start;
    logic             w_flush_exit;
    logic             w_rate_legal;
    logic             w_load_ok;
    logic             w_load_bad;
    logic             w_running;
    logic             w_running_nxt;
    logic [6:0]       w_phase_reload;

    // Legal rates are the powers of two from 4 to 128.
    always_comb begin
        w_rate_legal = 1'b0;
        case (rate_in)
            8'd4, 8'd8, 8'd16, 8'd32, 8'd64, 8'd128: w_rate_legal = 1'b1;
            default: w_rate_legal = 1'b0;
        endcase
    end

    assign w_load_ok  = rate_load & w_rate_legal;
    assign w_load_bad = rate_load & ~w_rate_legal;

    // Next-state decode; enable low dominates everything, including restarts.
    always_comb begin
        w_state_nxt   = r_state;
        w_flush_start = 1'b0;
        if (!enable) begin
            w_state_nxt = c_IDLE;
        end else begin
            case (r_state)
                c_IDLE: begin
                    w_state_nxt   = c_FLUSH;
                    w_flush_start = 1'b1;
                end
                c_FLUSH: begin
                    if (r_restart) begin
                        w_flush_start = 1'b1;
                    end else if (r_flush_cnt == c_FLUSH_LAST) begin
                        w_state_nxt = c_SETTLE;
                    end
                end
                c_SETTLE: begin
                    if (r_restart) begin
                        w_state_nxt   = c_FLUSH;
                        w_flush_start = 1'b1;
                    end else if (r_dec_clk && (r_settle_cnt == c_SETTLE_LAST)) begin
                        w_state_nxt = c_RUN;
                    end
                end
                default: begin
                    if (r_restart) begin
                        w_state_nxt   = c_FLUSH;
                        w_flush_start = 1'b1;
                    end
                end
            endcase
        end
    end

    assign w_flush_exit   = (r_state == c_FLUSH) && (w_state_nxt == c_SETTLE);
    assign w_running      = (r_state == c_SETTLE) || (r_state == c_RUN);
    assign w_running_nxt  = (w_state_nxt == c_SETTLE) || (w_state_nxt == c_RUN);
    // Low seven bits minus one also gives 127 for a rate of 128.
    assign w_phase_reload = r_dec_rate[6:0] - 7'd1;

    // State register and flush-length counter (restarts from zero on every flush start).
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= c_IDLE;
            r_flush_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_flush_start) begin
                r_flush_cnt <= '0;
            end else if ((r_state == c_FLUSH) && (w_state_nxt == c_FLUSH)) begin
                r_flush_cnt <= r_flush_cnt + c_FW'(1);
            end else begin
                r_flush_cnt <= '0;
            end
        end
    end

    // Rate bookkeeping: pending rate, active rate, restart request, sticky error.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_pending_rate <= DEFAULT_RATE;
            r_dec_rate     <= DEFAULT_RATE;
            r_restart      <= 1'b0;
            r_rate_err     <= 1'b0;
        end else begin
            if (w_load_ok) begin
                r_pending_rate <= rate_in;
            end
            if (w_flush_start) begin
                r_dec_rate <= r_pending_rate;
            end
            if (!enable) begin
                r_restart <= 1'b0;
            end else if (w_load_ok) begin
                r_restart <= 1'b1;
            end else if (w_flush_start) begin
                r_restart <= 1'b0;
            end
            if (w_load_ok) begin
                r_rate_err <= 1'b0;
            end else if (w_load_bad) begin
                r_rate_err <= 1'b1;
            end
        end
    end

    // Phase counter, decimation pulse, settle pulse count and output-valid strobe.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_phase      <= '0;
            r_dec_clk    <= 1'b0;
            r_settle_cnt <= '0;
            r_out_valid  <= 1'b0;
        end else begin
            if (w_flush_exit) begin
                r_phase <= w_phase_reload;
            end else if (w_running && w_running_nxt) begin
                r_phase <= (r_phase == 7'd0) ? w_phase_reload : (r_phase - 7'd1);
            end else begin
                r_phase <= '0;
            end
            r_dec_clk <= w_running && w_running_nxt && (r_phase == 7'd0);
            if ((r_state == c_SETTLE) && r_dec_clk) begin
                r_settle_cnt <= r_settle_cnt + c_SW'(1);
            end else if (r_state != c_SETTLE) begin
                r_settle_cnt <= '0;
            end
            // Valid only for pulses taken in RUN, and not if RUN is being left.
            r_out_valid <= r_dec_clk && (r_state == c_RUN) && (w_state_nxt == c_RUN);
        end
    end

    assign dec_rate  = r_dec_rate;
    assign dec_clk   = r_dec_clk;
    assign cic_reset = (r_state == c_IDLE) || (r_state == c_FLUSH);
    assign out_valid = r_out_valid;
    assign rate_err  = r_rate_err;
    assign state     = r_state;

endmodule
`default_nettype wire
